// File: rtl/control_pipeline.sv
// control_pipeline: carries decoder controls through the E/M/W pipeline registers with stall/flush, valid tracking and a retired-instruction count.
module control_pipeline #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_d_i,
  input  logic             reg_write_d_i,
  input  logic [2:0]       result_src_d_i,
  input  logic             mem_write_d_i,
  input  logic [1:0]       alu_op_d_i,
  input  logic [1:0]       branch_op_d_i,
  input  logic             width_op_d_i,
  input  logic             alu_src_d_i,
  input  logic             pc_base_src_d_i,
  input  logic             stall_e_i,
  input  logic             flush_e_i,
  input  logic             flush_m_i,
  output logic             valid_e_o,
  output logic             valid_m_o,
  output logic             valid_w_o,
  output logic [1:0]       alu_op_e_o,
  output logic [1:0]       branch_op_e_o,
  output logic             alu_src_e_o,
  output logic             pc_base_src_e_o,
  output logic             reg_write_e_o,
  output logic [2:0]       result_src_e_o,
  output logic             mem_write_e_o,
  output logic             width_op_e_o,
  output logic             reg_write_m_o,
  output logic [2:0]       result_src_m_o,
  output logic             mem_write_m_o,
  output logic             width_op_m_o,
  output logic             reg_write_w_o,
  output logic [2:0]       result_src_w_o,
  output logic [CNT_W-1:0] instret_o
);
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [2:0] result_src;
    logic       mem_write;
    logic [1:0] alu_op;
    logic [1:0] branch_op;
    logic       width_op;
    logic       alu_src;
    logic       pc_base_src;
  } ctrl_e_t;
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [2:0] result_src;
    logic       mem_write;
    logic       width_op;
  } ctrl_m_t;
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [2:0] result_src;
  } ctrl_w_t;
  ctrl_e_t e_d, e_q, d_in;
  ctrl_m_t m_d, m_q;
  ctrl_w_t w_d, w_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb begin
    d_in = {valid_d_i, reg_write_d_i & valid_d_i, result_src_d_i, mem_write_d_i & valid_d_i,
            alu_op_d_i, branch_op_d_i, width_op_d_i, alu_src_d_i, pc_base_src_d_i};
    e_d = flush_e_i ? '0 : stall_e_i ? e_q : d_in;
    // a held E instruction must not also advance into M
    m_d = (flush_m_i || (stall_e_i && !flush_e_i)) ? '0 :
          {e_q.valid, e_q.reg_write & e_q.valid, e_q.result_src, e_q.mem_write & e_q.valid, e_q.width_op};
    w_d = {m_q.valid, m_q.reg_write & m_q.valid, m_q.result_src};
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, w_q.valid};
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end
  assign valid_e_o       = e_q.valid;
  assign reg_write_e_o   = e_q.reg_write;
  assign result_src_e_o  = e_q.result_src;
  assign mem_write_e_o   = e_q.mem_write;
  assign alu_op_e_o      = e_q.alu_op;
  assign branch_op_e_o   = e_q.branch_op;
  assign width_op_e_o    = e_q.width_op;
  assign alu_src_e_o     = e_q.alu_src;
  assign pc_base_src_e_o = e_q.pc_base_src;
  assign valid_m_o       = m_q.valid;
  assign reg_write_m_o   = m_q.reg_write;
  assign result_src_m_o  = m_q.result_src;
  assign mem_write_m_o   = m_q.mem_write;
  assign width_op_m_o    = m_q.width_op;
  assign valid_w_o       = w_q.valid;
  assign reg_write_w_o   = w_q.reg_write;
  assign result_src_w_o  = w_q.result_src;
  assign instret_o       = cnt_q;
endmodule
